// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory access controller: bus width, FSM state
// encodings and requester port identifiers.
package mem_ctrl_pkg;

    localparam int unsigned WORD_SIZE = 16;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Requester port identifiers
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between the fetch (I) and data (D) requesters.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   i_req_i       fetch request
//   d_req_i       data request
//   update_i      record the current grant as the most recent winner
//   grant_c_o     combinational grant id (PORT_I / PORT_D)
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic update_i,
    output logic grant_c_o
);

    logic last_grant_q;
    logic last_grant_d;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_c_o = PORT_I;
        if (i_req_i && d_req_i) begin
            grant_c_o = ~last_grant_q;
        end else if (d_req_i) begin
            grant_c_o = PORT_D;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_i) begin
            last_grant_d = grant_c_o;
        end
    end

    // Reset to D so the first tie goes to the fetch port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences every cycle on the single memory port
// for the instruction-fetch and data requesters.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   i_req/i_addr/i_ack/i_rdata        fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata/
//   d_ack/d_rdata                     data requester (load/store)
//   err                               pulses with the ack of a timed-out access
//   readM/writeM/address/data         memory strobes, address and data bus
//   inputReady/ackOutput              memory read-valid / write-accepted
module mem_access_ctrl #(
    parameter int unsigned WORD_SIZE = mem_ctrl_pkg::WORD_SIZE,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);
    import mem_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]           state_q,   state_d;
    logic                 port_q,    port_d;
    logic [WORD_SIZE-1:0] addr_q,    addr_d;
    logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
    logic                 drive_q,   drive_d;
    logic                 readm_q,   readm_d;
    logic                 writem_q,  writem_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 i_ack_q,   i_ack_d;
    logic                 d_ack_q,   d_ack_d;
    logic                 err_q,     err_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

    logic grant;
    logic arb_update;

    mem_rr_arbiter u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req_i   (i_req),
        .d_req_i   (d_req),
        .update_i  (arb_update),
        .grant_c_o (grant)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        drive_d    = 1'b0;
        readm_d    = 1'b0;
        writem_d   = 1'b0;
        cnt_d      = cnt_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        arb_update = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    arb_update = 1'b1;
                    port_d     = grant;
                    cnt_d      = '0;
                    if (grant == PORT_I) begin
                        addr_d  = i_addr;
                        state_d = ST_RD;
                        readm_d = 1'b1;
                    end else begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (d_we) begin
                            state_d  = ST_WR;
                            writem_d = 1'b1;
                            drive_d  = 1'b1;
                        end else begin
                            state_d = ST_RD;
                            readm_d = 1'b1;
                        end
                    end
                end
            end

            // A response on the timeout edge still completes normally.
            ST_RD: begin
                if (inputReady) begin
                    state_d = ST_DONE;
                    i_ack_d = (port_q == PORT_I);
                    d_ack_d = (port_q == PORT_D);
                    if (port_q == PORT_I) begin
                        i_rdata_d = data;
                    end else begin
                        d_rdata_d = data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    i_ack_d = (port_q == PORT_I);
                    d_ack_d = (port_q == PORT_D);
                    if (port_q == PORT_I) begin
                        i_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    readm_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_WR: begin
                if (ackOutput) begin
                    state_d = ST_DONE;
                    i_ack_d = (port_q == PORT_I);
                    d_ack_d = (port_q == PORT_D);
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    i_ack_d = (port_q == PORT_I);
                    d_ack_d = (port_q == PORT_D);
                end else begin
                    writem_d = 1'b1;
                    drive_d  = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            readm_q   <= 1'b0;
            writem_q  <= 1'b0;
            cnt_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            readm_q   <= readm_d;
            writem_q  <= writem_d;
            cnt_q     <= cnt_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign data    = drive_q ? wdata_q : {WORD_SIZE{1'bz}};
    assign readM   = readm_q;
    assign writeM  = writem_q;
    assign address = addr_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
